// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: default geometry and word type shared by the RAM and its storage array
package dual_port_ram_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
   typedef logic [DATA_WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/dual_port_ram_array.sv
// dual_port_ram_array: flop-based register file with synchronous clear,
// one write port and a combinational read mux
module dual_port_ram_array
   import dual_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end
   // Read sees the pre-edge contents, which gives read-first behaviour on a same-address collision
   assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: single-clock RAM with independent write and read ports,
// registered read data and a synchronous clear of the whole array
module dual_port_ram
   import dual_port_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_enb,
   input  logic                  re_enb,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] data_out
);
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] data_d, data_q;
   dual_port_ram_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_array (
      .clk_i    (clock),
      .rst_i    (reset),
      .we_i     (wr_enb),
      .wr_addr_i(wr_addr),
      .wr_data_i(data_in),
      .rd_addr_i(rd_addr),
      .rd_data_o(rd_data)
   );
   always_comb data_d = re_enb ? rd_data : data_q;
   always_ff @(posedge clock) begin
      data_q <= reset ? '0 : data_d;
   end
   assign data_out = data_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed and random checks of the dual-port RAM against a reference model
module tb_dual_port_ram;
   logic       clock = 1'b0;
   logic       reset, wr_enb, re_enb;
   logic [7:0] data_in, data_out;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] model [16];
   logic [7:0] exp_q [$];
   logic [7:0] last;
   int         n_assert = 0;
   int         n_fail = 0;

   always #5 clock = ~clock;

   dual_port_ram dut (
      .clock   (clock),
      .reset   (reset),
      .wr_enb  (wr_enb),
      .re_enb  (re_enb),
      .data_in (data_in),
      .wr_addr (wr_addr),
      .rd_addr (rd_addr),
      .data_out(data_out)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One normal clock edge; expected read data is queued at the edge, popped when data_out settles
   task automatic cyc(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra, input string tag);
      @(negedge clock);
      reset = 1'b0; wr_enb = we; wr_addr = wa; data_in = wd; re_enb = re; rd_addr = ra;
      @(posedge clock);
      if (re) exp_q.push_back(model[ra]);
      if (we) model[wa] = wd;
      #1;
      if (re) last = exp_q.pop_front();
      check(tag, data_out, last);
   endtask

   // Reset edge with write and read also requested; both must be ignored
   task automatic rst_cyc(input logic [3:0] wa, input logic [7:0] wd, input string tag);
      @(negedge clock);
      reset = 1'b1; wr_enb = 1'b1; wr_addr = wa; data_in = wd; re_enb = 1'b1; rd_addr = wa;
      @(posedge clock);
      foreach (model[i]) model[i] = 8'h00;
      last = 8'h00;
      #1;
      check(tag, data_out, 8'h00);
   endtask

   initial begin
      reset = 1'b1; wr_enb = 1'b0; re_enb = 1'b0; data_in = '0; wr_addr = '0; rd_addr = '0;
      last = 8'h00;
      foreach (model[i]) model[i] = 8'h00;
      rst_cyc(4'd1, 8'h77, "reset_edge1");
      rst_cyc(4'd2, 8'h88, "reset_edge2");
      rst_cyc(4'd3, 8'h99, "reset_edge3");
      cyc(0, 0, 0, 1, 4'd0,  "post_reset_rd0");
      cyc(0, 0, 0, 1, 4'd2,  "post_reset_rd2");
      cyc(0, 0, 0, 1, 4'd15, "post_reset_rd15");
      cyc(1, 4'd3, 8'hA5, 0, 0, "wr3_hold");
      cyc(0, 0, 0, 1, 4'd3, "rd3_A5");
      cyc(1, 4'd7, 8'h11, 0, 0, "wr7_11");
      cyc(1, 4'd7, 8'h22, 1, 4'd7, "rw7_read_first");
      cyc(0, 0, 0, 1, 4'd7, "rd7_new");
      cyc(1, 4'd9, 8'h5A, 1, 4'd3, "rw_diff_rd3");
      cyc(0, 0, 0, 1, 4'd9, "rd9_5A");
      cyc(1, 4'd5, 8'hC3, 0, 0, "wr5_C3");
      cyc(0, 4'd5, 8'hFF, 0, 0, "wr_disabled_hold");
      cyc(0, 0, 0, 1, 4'd5, "rd5_unchanged");
      cyc(0, 4'd1, 8'hEE, 0, 4'd1, "re_off_hold");
      for (int i = 0; i < 40; i++)
         cyc(1, 4'($urandom_range(0, 15)), 8'($urandom), 0, 0, "rand_wr_hold");
      for (int a = 0; a < 16; a++)
         cyc(0, 0, 0, 1, 4'(a), "rand_rd");
      cyc(1, 4'd0, 8'h6B, 0, 0, "wr0_6B");
      rst_cyc(4'd0, 8'h3C, "reset_with_wr0");
      cyc(0, 0, 0, 1, 4'd0, "rd0_after_reset");
      cyc(0, 0, 0, 1, 4'd3, "rd3_cleared");
      cyc(1, 4'd0, 8'h3C, 0, 0, "wr0_after_reset");
      cyc(0, 0, 0, 1, 4'd0, "rd0_3C");
      cyc(1, 4'd15, 8'hF0, 1, 4'd0, "rw_top_addr");
      cyc(0, 0, 0, 1, 4'd15, "rd15_F0");
      check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
- REQ-001: Parameter DATA_WIDTH, default 8: data word width in bits.
- REQ-002: Parameter ADDR_WIDTH, default 4: address width in bits.
- REQ-003: Parameter DEPTH, default 16 (2**ADDR_WIDTH): number of words.
- REQ-004: clock  input  1  single clock; all state SHALL change on its rising edge only.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: wr_enb  input  1  write enable; a write is performed on the edge where it is 1.
- REQ-007: re_enb  input  1  read enable; a read is performed on the edge where it is 1.
- REQ-008: data_in  input  DATA_WIDTH  write data.
- REQ-009: wr_addr  input  ADDR_WIDTH  write address.
- REQ-010: rd_addr  input  ADDR_WIDTH  read address.
- REQ-011: data_out  output  DATA_WIDTH  registered read data.

Function
- REQ-012: Storage SHALL be DEPTH words of DATA_WIDTH bits, with independent write and read ports on the same clock.
- REQ-013: Write: on a rising edge with reset=0 and wr_enb=1, mem[wr_addr] <= data_in; no other word changes.
- REQ-014: Read: on a rising edge with reset=0 and re_enb=1, data_out <= mem[rd_addr]; latency is 1 cycle from address/enable sampling to data_out valid.
- REQ-015: With re_enb=0, data_out SHALL hold its previous value.
- REQ-016: With wr_enb=0, the memory SHALL remain unchanged regardless of wr_addr and data_in.
- REQ-017: A simultaneous read and write to the same address SHALL be read-first: data_out receives the old contents, and the new data is visible on the next read.
- REQ-018: A simultaneous read and write to different addresses SHALL both complete in the same cycle without interaction.
- REQ-019: Every address 0..DEPTH-1 is valid; there is no wrap-around or out-of-range behaviour.
- REQ-020: The block SHALL have no handshake, no busy state and no state machine; it accepts one read and one write every cycle.

Reset
- REQ-021: While reset=1 at a rising edge, data_out SHALL become 0 and every memory word SHALL be cleared to 0.
- REQ-022: Reset SHALL dominate: wr_enb and re_enb are ignored on any edge where reset=1.
- REQ-023: A reset asserted mid-operation SHALL discard any write or read on that edge; the first access after reset deasserts SHALL behave normally.

Structure
- REQ-024: A shared package dual_port_ram_pkg SHALL hold the default DATA_WIDTH, ADDR_WIDTH and DEPTH constants and a word typedef.
- REQ-025: The storage SHALL be a flop-based register file, because of the reset-clear requirement, in a single sub-module dual_port_ram_array that implements the write port, the clear and the combinational read mux. The top level SHALL contain the data_out register.

Verification
- REQ-026: Hold reset=1 for 3 edges -> data_out=8'h00; a read of any address after reset returns 8'h00.
- REQ-027: Write 8'hA5 to address 3, then read address 3 on the following edge -> data_out=8'hA5 one cycle after the read edge.
- REQ-028: Write and read address 7 on the same edge, where address 7 held 8'h11 and the new data is 8'h22 -> data_out=8'h11; the next read of address 7 -> 8'h22.
- REQ-029: Drive wr_enb=0 with wr_addr=5 and data_in=8'hFF, then read address 5 -> the prior value is unchanged; with re_enb=0 -> data_out holds the last read value.
- REQ-030: Run 40 random writes, then read all 16 addresses -> each data_out matches a reference model updated at the same edges.
- REQ-031: Assert reset on the same edge as a write of 8'h3C to address 0 -> address 0 reads back 8'h00.
